rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_frame_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rx_frame_ctrl
//  Purpose  : Receive-side frame filter. It queues accepted frames in a FIFO
//             and drives ACK/NAK requests to the transmitter.
//  Revision : 1.0  initial release
// ============================================================================
module rx_frame_ctrl #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             my_id,
    input  logic                   frm_valid,
    input  logic [1:0]             frm_dest,
    input  logic [1:0]             frm_src,
    input  logic [PAYLOAD_W-1:0]   frm_payload,
    input  logic                   frm_crc_err,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [1:0]             rd_src,
    output logic [PAYLOAD_W-1:0]   rd_payload,
    output logic                   ack_req,
    output logic                   ack_nak,
    output logic [1:0]             ack_dest,
    input  logic                   ack_done,
    output logic                   id_miss,
    output logic                   ack_lost,
    output logic [7:0]             cnt_ok,
    output logic [7:0]             cnt_crc,
    output logic [7:0]             cnt_ovf,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   fifo_full
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              EW       = PAYLOAD_W + 2;
    localparam logic [AW:0]     CNT_ONE  = 1;
    localparam logic [AW-1:0]   PTR_ONE  = 1;
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]      CNT_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [7:0]      cnt_ok_q, cnt_crc_q, cnt_ovf_q;
    logic            id_miss_q;

    state_t          state_q, state_d;
    logic            pend_v_q, pend_v_d;
    logic            pend_nak_q, pend_nak_d;
    logic [1:0]      pend_dest_q, pend_dest_d;
    logic            ack_nak_q, ack_nak_d;
    logic [1:0]      ack_dest_q, ack_dest_d;
    logic            ack_lost_q, ack_lost_d;

    logic            dest_match, is_good, pop, push, ovf;
    logic            resp_new, resp_nak;

    assign dest_match = frm_valid && (frm_dest == my_id);
    assign is_good    = dest_match && !frm_crc_err;
    assign pop        = rd_valid && rd_ready;
    // A same-cycle pop frees a slot, so a full FIFO can still take the push.
    assign push       = is_good && (!fifo_full || pop);
    assign ovf        = is_good && fifo_full && !pop;
    assign resp_new   = dest_match;
    assign resp_nak   = frm_crc_err || ovf;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {frm_src, frm_payload};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cnt_ok_q  <= '0;
            cnt_crc_q <= '0;
            cnt_ovf_q <= '0;
            id_miss_q <= 1'b0;
        end else begin
            id_miss_q <= frm_valid && !dest_match;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (push && cnt_ok_q != CNT_MAX)                  cnt_ok_q  <= cnt_ok_q + 8'd1;
            if (dest_match && frm_crc_err && cnt_crc_q != CNT_MAX) cnt_crc_q <= cnt_crc_q + 8'd1;
            if (ovf && cnt_ovf_q != CNT_MAX)                  cnt_ovf_q <= cnt_ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pend_v_q    <= 1'b0;
            pend_nak_q  <= 1'b0;
            pend_dest_q <= 2'd0;
            ack_nak_q   <= 1'b0;
            ack_dest_q  <= 2'd0;
            ack_lost_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_v_q    <= pend_v_d;
            pend_nak_q  <= pend_nak_d;
            pend_dest_q <= pend_dest_d;
            ack_nak_q   <= ack_nak_d;
            ack_dest_q  <= ack_dest_d;
            ack_lost_q  <= ack_lost_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_v_d    = pend_v_q;
        pend_nak_d  = pend_nak_q;
        pend_dest_d = pend_dest_q;
        ack_nak_d   = ack_nak_q;
        ack_dest_d  = ack_dest_q;
        ack_lost_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_v_q) begin
                    state_d     = S_REQ;
                    ack_nak_d   = pend_nak_q;
                    ack_dest_d  = pend_dest_q;
                    pend_v_d    = resp_new;
                    pend_nak_d  = resp_nak;
                    pend_dest_d = frm_src;
                end else if (resp_new) begin
                    state_d    = S_REQ;
                    ack_nak_d  = resp_nak;
                    ack_dest_d = frm_src;
                end
            end
            S_REQ, S_GAP: begin
                // The slot is judged as it stands this cycle; a full slot always wins.
                if (resp_new) begin
                    if (pend_v_q) begin
                        ack_lost_d = 1'b1;
                    end else begin
                        pend_v_d    = 1'b1;
                        pend_nak_d  = resp_nak;
                        pend_dest_d = frm_src;
                    end
                end
                if (state_q == S_REQ) begin
                    if (ack_done) state_d = S_GAP;
                end else if (pend_v_q) begin
                    state_d    = S_REQ;
                    ack_nak_d  = pend_nak_q;
                    ack_dest_d = pend_dest_q;
                    pend_v_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_valid   = (count_q != '0);
    assign rd_src     = mem_q[rd_ptr_q][EW-1 -: 2];
    assign rd_payload = mem_q[rd_ptr_q][PAYLOAD_W-1:0];
    assign fifo_count = count_q;
    assign fifo_full  = (count_q == FULL_CNT);
    assign ack_req    = (state_q == S_REQ);
    assign ack_nak    = ack_nak_q;
    assign ack_dest   = ack_dest_q;
    assign ack_lost   = ack_lost_q;
    assign id_miss    = id_miss_q;
    assign cnt_ok     = cnt_ok_q;
    assign cnt_crc    = cnt_crc_q;
    assign cnt_ovf    = cnt_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_frame_ctrl
//  Purpose  : Randomized and directed bench for rx_frame_ctrl, checked
//             against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rx_frame_ctrl;

    localparam int DEPTH = 4;
    localparam int PW    = 128;

    logic          clk = 1'b0;
    logic          rst, frm_valid, frm_crc_err, rd_ready, ack_done;
    logic [1:0]    my_id, frm_dest, frm_src;
    logic [PW-1:0] frm_payload;
    logic          rd_valid, ack_req, ack_nak, id_miss, ack_lost, fifo_full;
    logic [1:0]    rd_src, ack_dest;
    logic [PW-1:0] rd_payload;
    logic [7:0]    cnt_ok, cnt_crc, cnt_ovf;
    logic [2:0]    fifo_count;

    rx_frame_ctrl #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .my_id(my_id), .frm_valid(frm_valid),
        .frm_dest(frm_dest), .frm_src(frm_src), .frm_payload(frm_payload),
        .frm_crc_err(frm_crc_err), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_src(rd_src), .rd_payload(rd_payload), .ack_req(ack_req),
        .ack_nak(ack_nak), .ack_dest(ack_dest), .ack_done(ack_done),
        .id_miss(id_miss), .ack_lost(ack_lost), .cnt_ok(cnt_ok),
        .cnt_crc(cnt_crc), .cnt_ovf(cnt_ovf), .fifo_count(fifo_count),
        .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: FIFO as a queue, counters as integers, and the
    // responder as "busy presenting", "in gap" plus an optional waiting response.
    logic [PW+1:0] m_q[$];
    int   m_ok, m_crc, m_ovf;
    bit   m_busy, m_gap, m_wait_v, m_wait_nak, m_out_nak, m_miss, m_lost;
    logic [1:0] m_wait_dest, m_out_dest;

    task automatic chk(input string name, input logic [PW+1:0] act, input logic [PW+1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit have_new, new_nak, was_wait, pop;
        logic [1:0] new_dest;
        if (rst) begin
            m_q.delete();
            m_ok = 0; m_crc = 0; m_ovf = 0;
            m_busy = 0; m_gap = 0; m_wait_v = 0; m_miss = 0; m_lost = 0;
            m_out_nak = 0; m_out_dest = 0; m_wait_nak = 0; m_wait_dest = 0;
            return;
        end
        have_new = 0; new_nak = 0; new_dest = frm_src;
        m_miss = 0; m_lost = 0;
        pop = (m_q.size() > 0) && rd_ready;
        if (pop) void'(m_q.pop_front());
        if (frm_valid) begin
            if (frm_dest != my_id) m_miss = 1;
            else begin
                have_new = 1;
                if (frm_crc_err) begin
                    new_nak = 1;
                    if (m_crc < 255) m_crc++;
                end else if (m_q.size() < DEPTH) begin
                    m_q.push_back({frm_src, frm_payload});
                    if (m_ok < 255) m_ok++;
                end else begin
                    new_nak = 1;
                    if (m_ovf < 255) m_ovf++;
                end
            end
        end
        was_wait = m_wait_v;
        if (!m_busy && !m_gap) begin
            if (was_wait) begin
                m_busy = 1; m_out_nak = m_wait_nak; m_out_dest = m_wait_dest;
                m_wait_v = have_new; m_wait_nak = new_nak; m_wait_dest = new_dest;
            end else if (have_new) begin
                m_busy = 1; m_out_nak = new_nak; m_out_dest = new_dest;
            end
        end else begin
            if (have_new) begin
                if (was_wait) m_lost = 1;
                else begin m_wait_v = 1; m_wait_nak = new_nak; m_wait_dest = new_dest; end
            end
            if (m_busy) begin
                if (ack_done) begin m_busy = 0; m_gap = 1; end
            end else begin
                m_gap = 0;
                if (was_wait) begin
                    m_busy = 1; m_out_nak = m_wait_nak; m_out_dest = m_wait_dest;
                    m_wait_v = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", rd_valid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("rd_src", rd_src, m_q[0][PW+1:PW]);
                chk("rd_payload", rd_payload, m_q[0][PW-1:0]);
            end
            chk("fifo_count", fifo_count, m_q.size());
            chk("fifo_full", fifo_full, m_q.size() == DEPTH);
            chk("cnt_ok", cnt_ok, m_ok);
            chk("cnt_crc", cnt_crc, m_crc);
            chk("cnt_ovf", cnt_ovf, m_ovf);
            chk("ack_req", ack_req, m_busy);
            if (m_busy) begin
                chk("ack_nak", ack_nak, m_out_nak);
                chk("ack_dest", ack_dest, m_out_dest);
            end
            chk("id_miss", id_miss, m_miss);
            chk("ack_lost", ack_lost, m_lost);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic frame(input logic [1:0] d, input logic [1:0] s, input logic crc, input logic [PW-1:0] p);
        frm_valid = 1; frm_dest = d; frm_src = s; frm_crc_err = crc; frm_payload = p;
        tick();
        frm_valid = 0;
    endtask

    initial begin
        rst = 1; my_id = 1; frm_valid = 0; frm_dest = 0; frm_src = 0; frm_crc_err = 0;
        frm_payload = '0; rd_ready = 0; ack_done = 0;
        tick(); tick();
        chk_en = 1;
        chk("reset fifo_count", fifo_count, 0);
        chk("reset ack_req", ack_req, 0);
        rst = 0;

        // Good frame: queued next cycle and ACKed to its source.
        frame(2'd1, 2'd2, 1'b0, 128'h1234_A5);
        chk("ok rd_valid", rd_valid, 1);
        chk("ok payload lsb", rd_payload[7:0], 8'hA5);
        chk("ok rd_src", rd_src, 2);
        chk("ok cnt_ok", cnt_ok, 1);
        chk("ok ack_req", ack_req, 1);
        chk("ok ack_nak", ack_nak, 0);
        chk("ok ack_dest", ack_dest, 2);
        tick();
        chk("ok ack_req held", ack_req, 1);
        ack_done = 1; tick(); ack_done = 0;
        chk("gap ack_req", ack_req, 0);
        rd_ready = 1; tick(); rd_ready = 0;
        chk("pop empties", rd_valid, 0);

        // Destination mismatch.
        frame(2'd3, 2'd0, 1'b0, 128'h77);
        chk("miss id_miss", id_miss, 1);
        chk("miss ack_req", ack_req, 0);
        chk("miss fifo_count", fifo_count, 0);
        tick();
        chk("miss pulse ends", id_miss, 0);

        // CRC error NAKed to source 0.
        frame(2'd1, 2'd0, 1'b1, 128'h55);
        chk("crc cnt_crc", cnt_crc, 1);
        chk("crc ack_nak", ack_nak, 1);
        chk("crc ack_dest", ack_dest, 0);
        chk("crc fifo empty", fifo_count, 0);
        ack_done = 1; tick(); ack_done = 0; tick();

        // Overflow and pop-on-full.
        rst = 1; tick(); rst = 0;
        ack_done = 1;
        for (int i = 0; i < 4; i++) frame(2'd1, 2'(i), 1'b0, PW'(i + 10));
        chk("ovf full", fifo_full, 1);
        frame(2'd1, 2'd3, 1'b0, 128'h99);
        chk("ovf cnt_ovf", cnt_ovf, 1);
        chk("ovf cnt_ok", cnt_ok, 4);
        rd_ready = 1;
        frame(2'd1, 2'd3, 1'b0, 128'h9A);
        rd_ready = 0;
        chk("pop+push count", fifo_count, 4);
        chk("pop+push cnt_ok", cnt_ok, 5);
        ack_done = 0;

        // Pending slot and lost response.
        rst = 1; tick(); rst = 0;
        frame(2'd1, 2'd0, 1'b0, 128'h1);
        chk("pend first dest", ack_dest, 0);
        frame(2'd1, 2'd2, 1'b0, 128'h2);
        chk("pend no lost", ack_lost, 0);
        frame(2'd1, 2'd3, 1'b0, 128'h3);
        chk("pend lost", ack_lost, 1);
        tick();
        chk("lost pulse ends", ack_lost, 0);
        ack_done = 1; tick(); ack_done = 0;
        chk("pend gap", ack_req, 0);
        tick();
        chk("pend second req", ack_req, 1);
        chk("pend second dest", ack_dest, 2);

        // Reset in the middle of a request.
        rst = 1; tick(); rst = 0;
        chk("rst ack_req", ack_req, 0);
        chk("rst fifo_count", fifo_count, 0);
        chk("rst cnt_ok", cnt_ok, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) my_id = 2'($urandom());
            frm_valid   = $urandom_range(0, 1);
            frm_dest    = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : my_id;
            frm_src     = 2'($urandom());
            frm_crc_err = ($urandom_range(0, 7) == 0);
            frm_payload = {$urandom(), $urandom(), $urandom(), $urandom()};
            rd_ready    = ($urandom_range(0, 9) < 4);
            ack_done    = ($urandom_range(0, 9) < 3);
            tick();
        end

        // Long reset-free run so the counters reach saturation.
        rst = 0;
        for (int i = 0; i < 2500; i++) begin
            frm_valid   = 1;
            frm_dest    = my_id;
            frm_src     = 2'($urandom());
            frm_crc_err = ($urandom_range(0, 1) == 0);
            frm_payload = {$urandom(), $urandom(), $urandom(), $urandom()};
            rd_ready    = ($urandom_range(0, 9) < 6);
            ack_done    = $urandom_range(0, 1);
            tick();
        end
        frm_valid = 0;
        chk("sat cnt_ok", cnt_ok, 8'hFF);
        chk("sat cnt_crc", cnt_crc, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
